pc_sequencer: RTL

Parametrised program-counter sequencer for the MIPS CPU fetch stage. It replaces the plain PC register and owns the branch delay slot itself. It accepts redirect requests from decode/execute, inserts the one-instruction delay slot, and detects the halt condition (a jump to HALT_ADDR). On halt it freezes fetch. It drives the instruction-memory address and reports whether the current fetch is a delay-slot instruction.

---
 rtl/pc_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC sequencer with delay slot and halt detection
// Optional feature macro: PC_EXCEPTION_EN (adds exc_req and exception vectoring).
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'hBFC00000),
    parameter logic [WIDTH-1:0] HALT_ADDR    = '0,
    parameter logic [WIDTH-1:0] INCR         = WIDTH'(4),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'hBFC00380)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
`ifdef PC_EXCEPTION_EN
    input  logic             exc_req,
`endif
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_incr,
    output logic             in_delay_slot,
    output logic             halt
);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DELAY  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             ds_q, ds_d;
    logic             halt_q, halt_d;

    assign pc            = pc_q;
    assign pc_plus_incr  = pc_q + INCR;
    assign in_delay_slot = ds_q;
    assign halt          = halt_q;

`ifndef PC_EXCEPTION_EN
    logic unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= NORMAL;
            pc_q    <= RESET_VECTOR;
            tgt_q   <= '0;
            ds_q    <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            ds_q    <= ds_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        ds_d    = ds_q;
        halt_d  = halt_q;

        case (state_q)
            NORMAL: begin
                if (!stall) begin
                    pc_d = pc_plus_incr;
                    if (redirect_valid) begin
                        tgt_d   = redirect_target;
                        state_d = DELAY;
                        ds_d    = 1'b1;
                    end
                end
            end
            DELAY: begin
                // Branches inside the delay slot lose to the pending redirect.
                if (!stall) begin
                    ds_d = 1'b0;
                    if (tgt_q != HALT_ADDR) begin
                        pc_d    = tgt_q;
                        state_d = NORMAL;
                    end else begin
                        halt_d  = 1'b1;
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
            end
            default: begin
                state_d = NORMAL;
                ds_d    = 1'b0;
            end
        endcase

`ifdef PC_EXCEPTION_EN
        if (!stall && exc_req && (state_q != HALTED)) begin
            pc_d    = EXC_VECTOR;
            state_d = NORMAL;
            ds_d    = 1'b0;
            tgt_d   = '0;
            halt_d  = halt_q;
        end
`endif
    end

endmodule
